// File: rtl/reorder_buffer_pkg.sv
// Shared widths and types for the reorder buffer and its clients.
// Covers the ROB index width plus the register-address and data bus widths.
package reorder_buffer_pkg;

   localparam int DEF_ROB_ADDR_WIDTH = 4;
   localparam int ROB_SIZE           = 1 << DEF_ROB_ADDR_WIDTH;
   localparam int REG_ADDR_W         = 5;
   localparam int DATA_W             = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     data_t;

   typedef struct packed {
      logic      en;
      logic      restore;
      reg_addr_t addr;
      data_t     data;
   } commit_t;

   function automatic commit_t commit_idle();
      return '0;
   endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Rename/writeback/operand/commit signals between the reorder buffer and the core.
// The ROB side uses the slave modport.
interface reorder_buffer_if
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_ADDR_WIDTH = DEF_ROB_ADDR_WIDTH
);

   logic                      alloc_en;
   reg_addr_t                 alloc_addr;
   logic                      alloc_ready;
   logic [ROB_ADDR_WIDTH-1:0] alloc_id;

   logic                      wb_en;
   logic [ROB_ADDR_WIDTH-1:0] wb_id;
   data_t                     wb_data;
   logic                      wb_exc;

   logic [ROB_ADDR_WIDTH-1:0] read_id_1;
   logic [ROB_ADDR_WIDTH-1:0] read_id_2;
   logic                      read_ready_1;
   logic                      read_ready_2;
   data_t                     read_data_1;
   data_t                     read_data_2;

   logic                      commit_en;
   logic                      commit_restore;
   reg_addr_t                 commit_addr;
   data_t                     commit_data;

   modport master (
      output alloc_en, alloc_addr, wb_en, wb_id, wb_data, wb_exc, read_id_1, read_id_2,
      input  alloc_ready, alloc_id, read_ready_1, read_ready_2, read_data_1, read_data_2,
      input  commit_en, commit_restore, commit_addr, commit_data
   );

   modport slave (
      input  alloc_en, alloc_addr, wb_en, wb_id, wb_data, wb_exc, read_id_1, read_id_2,
      output alloc_ready, alloc_id, read_ready_1, read_ready_2, read_data_1, read_data_2,
      output commit_en, commit_restore, commit_addr, commit_data
   );

endinterface

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping index counter used for the ROB head and tail pointers.
// clear has priority over inc.
module rob_ptr #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, accepts out-of-order writebacks,
// retires one done entry per cycle from head, and flushes on an excepting head.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_ADDR_WIDTH = DEF_ROB_ADDR_WIDTH
) (
   input logic             clk,
   input logic             rst,
   reorder_buffer_if.slave rob
);

   localparam int DEPTH = 1 << ROB_ADDR_WIDTH;
   localparam int CW    = ROB_ADDR_WIDTH + 1;

   typedef logic [ROB_ADDR_WIDTH-1:0] id_t;

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] done;
   logic [DEPTH-1:0] exc;
   reg_addr_t        dest [DEPTH];
   data_t            data [DEPTH];
   logic [CW-1:0]    count;
   id_t              head;
   id_t              tail;
   commit_t          commit_q;

   logic alloc_ready;
   logic alloc_fire;
   logic head_commit;
   logic head_restore;
   logic wb_hit;
   logic rd_ready_1;
   logic rd_ready_2;

   // alloc_ready looks only at the current count, so a same-cycle retire frees nothing yet
   assign alloc_ready  = (count < CW'(DEPTH));
   assign head_commit  = valid[head] & done[head] & ~exc[head];
   assign head_restore = valid[head] & done[head] & exc[head];
   assign alloc_fire   = rob.alloc_en & alloc_ready & ~head_restore;
   assign wb_hit       = rob.wb_en & valid[rob.wb_id] & ~head_restore;

   rob_ptr #(.WIDTH(ROB_ADDR_WIDTH)) u_head (
      .clk   (clk),
      .rst   (rst),
      .clear (head_restore),
      .inc   (head_commit),
      .ptr   (head)
   );

   rob_ptr #(.WIDTH(ROB_ADDR_WIDTH)) u_tail (
      .clk   (clk),
      .rst   (rst),
      .clear (head_restore),
      .inc   (alloc_fire),
      .ptr   (tail)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= '0;
         done     <= '0;
         exc      <= '0;
         count    <= '0;
         commit_q <= commit_idle();
      end else if (head_restore) begin
         valid            <= '0;
         done             <= '0;
         exc              <= '0;
         count            <= '0;
         commit_q         <= commit_idle();
         commit_q.restore <= 1'b1;
      end else begin
         commit_q <= commit_idle();
         if (head_commit) begin
            commit_q.en   <= 1'b1;
            commit_q.addr <= dest[head];
            commit_q.data <= data[head];
            valid[head]   <= 1'b0;
         end
         if (wb_hit) begin
            done[rob.wb_id] <= 1'b1;
            exc[rob.wb_id]  <= rob.wb_exc;
         end
         // head and tail never coincide here: commit needs count>0, alloc needs count<DEPTH
         if (alloc_fire) begin
            valid[tail] <= 1'b1;
            done[tail]  <= 1'b0;
            exc[tail]   <= 1'b0;
         end
         case ({alloc_fire, head_commit})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage: validity is tracked by the control bits above
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         dest[tail] <= rob.alloc_addr;
      end
      if (wb_hit) begin
         data[rob.wb_id] <= rob.wb_data;
      end
   end

   assign rd_ready_1 = valid[rob.read_id_1] & done[rob.read_id_1];
   assign rd_ready_2 = valid[rob.read_id_2] & done[rob.read_id_2];

   assign rob.alloc_ready    = alloc_ready;
   assign rob.alloc_id       = tail;
   assign rob.read_ready_1   = rd_ready_1;
   assign rob.read_ready_2   = rd_ready_2;
   assign rob.read_data_1    = rd_ready_1 ? data[rob.read_id_1] : '0;
   assign rob.read_data_2    = rd_ready_2 ? data[rob.read_id_2] : '0;
   assign rob.commit_en      = commit_q.en;
   assign rob.commit_restore = commit_q.restore;
   assign rob.commit_addr    = commit_q.addr;
   assign rob.commit_data    = commit_q.data;

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_ADDR_WIDTH, default 4, the entry index width; depth is 2**ROB_ADDR_WIDTH (16).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port alloc_en, input, 1, allocation request from rename.
REQ-005 SHALL have port alloc_addr, input, REG_ADDR_BUS, destination architectural register of the new entry.
REQ-006 SHALL have port alloc_ready, output, 1, high when an entry is free (count < depth).
REQ-007 SHALL have port alloc_id, output, ROB_ADDR_BUS, tail index; rename drives it to the regfile's write_ref_id.
REQ-008 SHALL have port wb_en, input, 1, result writeback strobe.
REQ-009 SHALL have port wb_id, input, ROB_ADDR_BUS, entry being written back.
REQ-010 SHALL have port wb_data, input, DATA_BUS, result value.
REQ-011 SHALL have port wb_exc, input, 1, result raised an exception or mispredict.
REQ-012 SHALL have ports read_id_1 and read_id_2, input, ROB_ADDR_BUS, operand lookup indices.
REQ-013 SHALL have ports read_ready_1 and read_ready_2, output, 1, entry valid and done.
REQ-014 SHALL have ports read_data_1 and read_data_2, output, DATA_BUS, entry value, zero when not ready.
REQ-015 SHALL have ports commit_en, commit_restore, commit_addr and commit_data, output, 1/1/REG_ADDR_BUS/DATA_BUS, registered commit to the regfile.

Function
REQ-016 SHALL store per entry: valid, done, exc, dest addr and data; head, tail and count (ROB_ADDR_WIDTH+1 bits).
REQ-017 SHALL accept an allocation when alloc_en && alloc_ready: entry[tail] becomes valid with done=0 and exc=0, tail increments mod depth, and alloc_id equals the pre-increment tail.
REQ-018 SHALL ignore alloc_en when full; alloc_ready SHALL use the current count, so a same-cycle commit does not free a slot until the next cycle.
REQ-019 SHALL set done=1 and store data and exc on wb_en when entry[wb_id] is valid; writeback to an invalid entry SHALL be dropped.
REQ-020 SHALL make read_ready/read_data combinational from the stored entry state; same-cycle writeback SHALL NOT be bypassed.
REQ-021 SHALL, at a clock edge where the head is valid and done with exc=0, register commit_en=1, commit_restore=0, commit_addr=dest and commit_data=data, free the head, and increment head mod depth.
REQ-022 SHALL retire at most one entry per cycle; otherwise commit_en=0, commit_restore=0 and commit_addr/commit_data=0.
REQ-023 SHALL, when the head is done with exc=1, register commit_restore=1 with commit_en=0, addr=0 and data=0, clear all valid bits, set head=tail=count=0, and discard any same-cycle alloc or wb.
REQ-024 SHALL commit a writeback sampled at edge k no earlier than edge k+1, with commit outputs visible in the cycle after edge k+1.
REQ-025 SHALL update count by +1 (alloc only), -1 (commit only), 0 (both or neither), with pointers wrapping from 15 to 0.
REQ-026 SHALL never commit when empty; an empty head SHALL produce idle commit outputs.

Reset
REQ-027 SHALL, while rst=1 at an edge, clear every valid, done and exc bit, set head=tail=count=0 and all commit outputs=0, and ignore all other inputs.
REQ-028 SHALL show alloc_ready=1 and alloc_id=0 in the cycle after reset; rst asserted mid-operation SHALL abandon all in-flight entries with no restore pulse.

Structure
REQ-029 SHALL take ROB_ADDR_WIDTH, ROB_ADDR_BUS and ROB_SIZE from the shared rob.v, and REG_ADDR_BUS and DATA_BUS from bus.v.
REQ-030 SHALL instantiate sub-module rob_ptr twice (head, tail), a wrapping ROB_ADDR_WIDTH counter with inc and clear inputs; entry storage SHALL stay inline.

Verification
REQ-031 SHALL cover: alloc reg 1 -> alloc_id=0; wb id0 data 0x12345678 -> commit_en=1, addr=1, data=0x12345678 two edges later.
REQ-032 SHALL cover: 16 allocs -> alloc_ready=0 and a 17th alloc ignored; retire head -> alloc_ready=1 and the next alloc_id=0 (wrap).
REQ-033 SHALL cover: out-of-order wb of id1 (0xabcdef00) before id0 -> no commit until id0 done, then commits in order id0 then id1 on consecutive cycles.
REQ-034 SHALL cover: wb id0 with wb_exc=1 while ids 1-3 are pending -> one cycle of commit_restore=1 and commit_en=0, then count=0 and alloc_id=0.
REQ-035 SHALL cover: read_id_1=0x0a for a done entry holding 0x55 -> read_ready_1=1, read_data_1=0x55; an undone entry -> ready=0, data=0.
REQ-036 SHALL cover: rst asserted with 5 pending entries -> alloc_id=0, commit outputs 0, and no restore pulse.
